// File: rtl/oled_spi_monitor.sv
// oled_spi_monitor: passive decoder of the 4-wire OLED SPI stream into command bytes and RGB565 pixels.
// Define OLED_MON_CHECKSUM_EN to build the per-frame pixel checksum; otherwise frame_checksum is 0.
module oled_spi_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_PIXELS  = 6144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        d_cn,
  output logic [7:0]  byte_out,
  output logic        cmd_valid,
  output logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        abort_err,
  output logic [15:0] frame_checksum
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [SYNC_STAGES-1:0] cs_q, sclk_q, sdin_q, dcn_q;
  logic cs_p, sclk_p, cs_s, sclk_s, sdin_s, dcn_s;
  logic cs_fall, cs_rise, sclk_rise;
  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] sh;
  logic byte_stb, byte_dc, part_abort, cs_end;
  logic phase_lo, phase_nx, is_cmd, is_dat, pix, last, drop;
  logic [7:0] hi;
  logic [12:0] nidx;
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign sdin_s    = sdin_q[SYNC_STAGES-1];
  assign dcn_s     = dcn_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_s & cs_p;
  assign cs_rise   = cs_s & ~cs_p;
  assign sclk_rise = sclk_s & ~sclk_p & ~cs_s;
  // cs resets low so a cs already held low at reset release never looks like a fresh fall
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q   <= '0;
      sclk_q <= '0;
      sdin_q <= '0;
      dcn_q  <= '0;
      cs_p   <= 1'b0;
      sclk_p <= 1'b0;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sdin_q <= {sdin_q[SYNC_STAGES-2:0], sdin};
      dcn_q  <= {dcn_q[SYNC_STAGES-2:0], d_cn};
      cs_p   <= cs_s;
      sclk_p <= sclk_s;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      sh         <= '0;
      byte_out   <= '0;
      byte_dc    <= 1'b0;
      byte_stb   <= 1'b0;
      part_abort <= 1'b0;
      cs_end     <= 1'b0;
    end else begin
      byte_stb   <= 1'b0;
      part_abort <= 1'b0;
      cs_end     <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall) begin
          state   <= SHIFT;
          bit_cnt <= '0;
        end
      end else if (cs_rise) begin
        state      <= IDLE;
        part_abort <= bit_cnt != 3'd0;
        cs_end     <= 1'b1;
        bit_cnt    <= '0;
      end else if (sclk_rise) begin
        sh      <= {sh[5:0], sdin_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_out <= {sh, sdin_s};
          byte_dc  <= dcn_s;
          byte_stb <= 1'b1;
        end
      end
    end
  end
  assign is_cmd   = byte_stb & ~byte_dc;
  assign is_dat   = byte_stb & byte_dc;
  assign pix      = is_dat & phase_lo;
  assign last     = nidx == 13'(NUM_PIXELS - 1);
  assign phase_nx = is_dat ? ~phase_lo : is_cmd ? 1'b0 : phase_lo;
  // a half pixel is lost either to a command or to cs ending the transfer; both fold into one pulse
  assign drop     = (is_cmd & phase_lo) | (cs_end & phase_nx);
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      abort_err   <= 1'b0;
      phase_lo    <= 1'b0;
      hi          <= '0;
      nidx        <= '0;
      pixel_data  <= '0;
      pixel_index <= '0;
    end else begin
      cmd_valid   <= is_cmd;
      pixel_valid <= pix;
      frame_done  <= pix & last;
      abort_err   <= part_abort | drop;
      phase_lo    <= phase_nx & ~cs_end;
      if (is_cmd) nidx <= '0;
      else if (pix) nidx <= last ? '0 : nidx + 13'd1;
      if (is_dat & ~phase_lo) hi <= byte_out;
      if (pix) begin
        pixel_data  <= {hi, byte_out};
        pixel_index <= nidx;
      end
    end
  end
`ifdef OLED_MON_CHECKSUM_EN
  logic [15:0] acc, sum;
  assign sum = acc + {hi, byte_out};
  always_ff @(posedge clk) begin
    if (reset) begin
      acc            <= '0;
      frame_checksum <= '0;
    end else if (is_cmd) begin
      acc <= '0;
    end else if (pix) begin
      acc <= last ? 16'h0000 : sum;
      if (last) frame_checksum <= sum;
    end
  end
`else
  assign frame_checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_oled_spi_monitor.sv
// tb_oled_spi_monitor: randomized SPI stimulus, expectations queued from a frame-level model, checked by a monitor.
module tb_oled_spi_monitor;
  localparam int SYNC = 2;
  localparam int NP   = 64;
  logic clk = 1'b0, reset = 1'b1, cs = 1'b1, sclk = 1'b0, sdin = 1'b0, d_cn = 1'b0;
  logic [7:0] byte_out;
  logic [15:0] pixel_data, frame_checksum;
  logic [12:0] pixel_index;
  logic cmd_valid, pixel_valid, frame_done, abort_err;
  oled_spi_monitor #(.SYNC_STAGES(SYNC), .NUM_PIXELS(NP)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .sdin(sdin), .d_cn(d_cn),
    .byte_out(byte_out), .cmd_valid(cmd_valid), .pixel_data(pixel_data),
    .pixel_index(pixel_index), .pixel_valid(pixel_valid), .frame_done(frame_done),
    .abort_err(abort_err), .frame_checksum(frame_checksum)
  );
  always #5 clk = ~clk;
  typedef struct { logic [15:0] d; logic [12:0] i; logic fd; logic [15:0] ck; } pix_t;
  logic [7:0] cmd_q[$];
  pix_t pix_q[$];
  int abort_exp = 0, abort_seen = 0, ncmp = 0, nerr = 0, cyc = 0, rise_cyc = 0;
  // frame-level model of the decoded stream
  bit half = 0;
  logic [7:0] m_hi = 0, last_byte = 0;
  int nidx = 0;
  logic [15:0] acc = 0, ck_last = 0, last_pix = 0;
  logic [12:0] last_idx = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    ncmp++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, g, e);
    end
  endtask
  task automatic fail(input string n);
    ncmp++;
    nerr++;
    $display("FAIL %s", n);
  endtask
  task automatic model_clear();
    half = 0; m_hi = 0; last_byte = 0; nidx = 0; acc = 0; ck_last = 0; last_pix = 0; last_idx = 0;
  endtask
  task automatic model_byte(input logic dc, input logic [7:0] b);
    pix_t p;
    last_byte = b;
    if (!dc) begin
      if (half) abort_exp++;
      half = 0;
      nidx = 0;
      acc = 0;
      cmd_q.push_back(b);
    end else if (!half) begin
      m_hi = b;
      half = 1;
    end else begin
      p.d = {m_hi, b};
      p.i = 13'(nidx);
      p.fd = nidx == NP - 1;
      acc = acc + p.d;
`ifdef OLED_MON_CHECKSUM_EN
      if (p.fd) ck_last = acc;
`endif
      p.ck = ck_last;
      if (p.fd) acc = 0;
      pix_q.push_back(p);
      last_pix = p.d;
      last_idx = p.i;
      nidx = p.fd ? 0 : nidx + 1;
      half = 0;
    end
  endtask
  task automatic bits(input logic dc, input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdin = b[i];
      d_cn = dc;
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (i == 0) rise_cyc = cyc;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic sb(input logic dc, input logic [7:0] b);
    model_byte(dc, b);
    bits(dc, b, 8);
  endtask
  task automatic cs_lo();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic cs_hi(input bit partial);
    if (partial || half) abort_exp++;
    half = 0;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("reset outputs", {byte_out, cmd_valid, pixel_data, pixel_index, pixel_valid,
        frame_done, abort_err, frame_checksum}, 64'h0);
  endtask
  task automatic hold_chk();
    chk("byte_out hold", byte_out, last_byte);
    chk("pixel_data hold", pixel_data, last_pix);
    chk("pixel_index hold", pixel_index, last_idx);
  endtask
  pix_t mp;
  always @(negedge clk) if (!reset) begin
    if (cmd_valid) begin
      if (cmd_q.size() == 0) fail("cmd_valid unexpected");
      else chk("cmd byte_out", byte_out, cmd_q.pop_front());
      chk("cmd latency", cyc - rise_cyc, SYNC + 2);
    end
    if (pixel_valid) begin
      if (pix_q.size() == 0) fail("pixel_valid unexpected");
      else begin
        mp = pix_q.pop_front();
        chk("pixel_data", pixel_data, mp.d);
        chk("pixel_index", pixel_index, mp.i);
        chk("frame_done", frame_done, mp.fd);
        chk("frame_checksum", frame_checksum, mp.ck);
      end
      chk("pixel latency", cyc - rise_cyc, SYNC + 2);
    end else if (frame_done) fail("frame_done without pixel_valid");
    if (abort_err) begin
      if (abort_seen >= abort_exp) fail("abort_err unexpected");
      abort_seen++;
    end
  end
  initial begin
    #3ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    cs_lo(); sb(0, 8'hAF); cs_hi(0);
    hold_chk();
    cs_lo(); sb(1, 8'hF8); sb(1, 8'h00); sb(1, 8'h07); sb(1, 8'hE0); cs_hi(0);
    hold_chk();
    cs_lo(); sb(0, 8'h15);
    for (int k = 0; k < NP + 1; k++) begin sb(1, 8'h00); sb(1, 8'h01); end
    cs_hi(0);
    hold_chk();
    cs_lo(); bits(0, 8'hFF, 5); cs_hi(1);
    cs_lo(); sb(0, 8'h3C); cs_hi(0);
    hold_chk();
    cs_lo(); sb(1, 8'h12); sb(0, 8'h15); sb(1, 8'hAB); sb(1, 8'hCD); cs_hi(0);
    hold_chk();
    cs_lo(); sb(1, 8'h55); cs_hi(0);
    cs_lo(); sb(1, 8'hAB); bits(1, 8'h5A, 3);
    do_reset();
    cs_lo(); sb(1, 8'h12); sb(1, 8'h34); cs_hi(0);
    hold_chk();
    for (int t = 0; t < 40; t++) begin
      cs_lo();
      for (int j = $urandom_range(1, 6); j > 0; j--)
        sb(logic'($urandom_range(0, 3) != 0), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        bits(1'b1, 8'($urandom), $urandom_range(1, 7));
        cs_hi(1);
      end else cs_hi(0);
      hold_chk();
    end
    repeat (20) @(negedge clk);
    chk("cmd queue drained", cmd_q.size(), 0);
    chk("pixel queue drained", pix_q.size(), 0);
    chk("abort count", abort_seen, abort_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
